// File: rtl/tt_sweep_checker_pkg.sv
// tt_sweep_checker_pkg: state encoding and default sizing for the sweep checker
package tt_sweep_checker_pkg;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DRIVE  = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;
  localparam int DEF_N      = 2;
  localparam int DEF_SETTLE = 1;
endpackage

// File: rtl/tt_settle_timer.sv
// tt_settle_timer: counts enabled cycles and flags the last one of a SETTLE-long hold
module tt_settle_timer import tt_sweep_checker_pkg::*; #(
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int W = SETTLE > 1 ? $clog2(SETTLE) : 1;
  localparam logic [W-1:0] LIM = W'(SETTLE - 1);
  logic [W-1:0] cnt;
  assign expire = en && cnt == LIM;
  // hold counter: cleared outside the hold, advances once per held cycle
  always_ff @(posedge clk)
    if (!rst_n || clr) cnt <= '0;
    else if (en) cnt <= cnt + W'(1);
endmodule

// File: rtl/tt_sweep_checker.sv
// tt_sweep_checker: sweeps all N-bit vectors into a DUT pair and records output mismatches
module tt_sweep_checker import tt_sweep_checker_pkg::*; #(
  parameter int N      = DEF_N,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic [N-1:0] vec,
  input  logic         r_a,
  input  logic         r_b,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_count,
  output logic         err_valid,
  output logic [N-1:0] first_err_vec
);
  localparam logic [N-1:0] LAST = {N{1'b1}};
  logic [1:0] state, nxt;
  logic       expire, go;
  assign go = start && (state == IDLE || state == DONE);
  tt_settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state != DRIVE),
    .en     (state == DRIVE),
    .expire (expire)
  );
  // state register
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // next state: the last vector ends the sweep instead of wrapping
  always_comb begin
    nxt = state;
    if (go) nxt = DRIVE;
    else if (state == DRIVE && expire) nxt = SAMPLE;
    else if (state == SAMPLE) nxt = vec == LAST ? DONE : DRIVE;
  end
  // status outputs decoded from state
  always_comb begin
    busy = state == DRIVE || state == SAMPLE;
    done = state == DONE;
    pass = state == DONE && err_count == '0;
  end
  // vector advance and mismatch capture; only the first mismatch is latched
  always_ff @(posedge clk)
    if (!rst_n) begin
      vec           <= '0;
      err_count     <= '0;
      err_valid     <= 1'b0;
      first_err_vec <= '0;
    end else if (go) begin
      vec           <= '0;
      err_count     <= '0;
      err_valid     <= 1'b0;
      first_err_vec <= '0;
    end else if (state == SAMPLE) begin
      if (r_a != r_b) begin
        err_count <= err_count + (N+1)'(1);
        if (!err_valid) begin
          err_valid     <= 1'b1;
          first_err_vec <= vec;
        end
      end
      if (vec != LAST) vec <= vec + N'(1);
    end
endmodule

// File: tb/tb_tt_sweep_checker.sv
// tb_tt_sweep_checker: directed checks of the sweep checker against hand-computed results
module tb_tt_sweep_checker;
  logic clk = 1'b0, rst_n = 1'b0, start2 = 1'b0, start3 = 1'b0;
  logic [1:0] vec2, fev2;
  logic [2:0] vec3, fev3, ec2;
  logic [3:0] ec3;
  logic ra2, rb2, ra3, rb3, busy2, done2, pass2, ev2, busy3, done3, pass3, ev3;
  int mode = 0, errors = 0, checks = 0;
  always #5 clk = ~clk;
  assign ra2 = ~vec2[1] & vec2[0];
  assign rb2 = mode == 0 ? ~(vec2[1] | ~vec2[0]) : mode == 1 ? 1'b0 : ~ra2;
  assign ra3 = (vec3[2] & vec3[1]) | vec3[0];
  assign rb3 = ~(~(vec3[2] & vec3[1]) & ~vec3[0]);
  tt_sweep_checker #(.N(2), .SETTLE(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .vec(vec2), .r_a(ra2), .r_b(rb2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(ec2), .err_valid(ev2),
    .first_err_vec(fev2));
  tt_sweep_checker #(.N(3), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .vec(vec3), .r_a(ra3), .r_b(rb3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(ec3), .err_valid(ev3),
    .first_err_vec(fev3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse2();
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
  endtask

  task automatic wait_done2(input string name);
    int n = 0;
    while (!done2 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (!done2) begin
      $display("FAIL %s: done not seen, got %b need 1", name, done2);
      errors++;
    end
  endtask

  task automatic check_result2(input string name, input logic [2:0] ec, input logic [1:0] fev,
                               input logic ev, input logic ps);
    checks++;
    if ({ec2, fev2, ev2, pass2} !== {ec, fev, ev, ps}) begin
      $display("FAIL %s: ec=%0d fev=%b ev=%b pass=%b, need ec=%0d fev=%b ev=%b pass=%b",
               name, ec2, fev2, ev2, pass2, ec, fev, ev, ps);
      errors++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({vec2, ec2, fev2, busy2, done2, pass2, ev2} !== '0) begin
      $display("FAIL reset2: got %b need 0", {vec2, ec2, fev2, busy2, done2, pass2, ev2});
      errors++;
    end
    checks++;
    if ({vec3, ec3, fev3, busy3, done3, pass3, ev3} !== '0) begin
      $display("FAIL reset3: got %b need 0", {vec3, ec3, fev3, busy3, done3, pass3, ev3});
      errors++;
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_equal();
    mode = 0;
    pulse2();
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      checks++;
      if (vec2 !== 2'(k >> 1) || busy2 !== 1'b1 || done2 !== 1'b0) begin
        $display("FAIL seq edge%0d: vec=%0d busy=%b done=%b need vec=%0d busy=1 done=0",
                 k, vec2, busy2, done2, k >> 1);
        errors++;
      end
    end
    tick();
    checks++;
    if (done2 !== 1'b1 || busy2 !== 1'b0 || vec2 !== 2'd3) begin
      $display("FAIL done_edge8: done=%b busy=%b vec=%0d need 1 0 3", done2, busy2, vec2);
      errors++;
    end
    check_result2("equal", 3'd0, 2'b00, 1'b0, 1'b1);
    tick();
    tick();
    checks++;
    if (done2 !== 1'b1 || vec2 !== 2'd3) begin
      $display("FAIL done_hold: done=%b vec=%0d need 1 3", done2, vec2);
      errors++;
    end
  endtask

  task automatic test_single_err();
    mode = 1;
    pulse2();
    checks++;
    if (done2 !== 1'b0 || busy2 !== 1'b1 || ec2 !== 3'd0) begin
      $display("FAIL restart_from_done: done=%b busy=%b ec=%0d need 0 1 0", done2, busy2, ec2);
      errors++;
    end
    wait_done2("single_wait");
    check_result2("single", 3'd1, 2'b01, 1'b1, 1'b0);
  endtask

  task automatic test_all_wrong();
    mode = 2;
    pulse2();
    wait_done2("allwrong_wait");
    check_result2("allwrong", 3'd4, 2'b00, 1'b1, 1'b0);
  endtask

  task automatic test_mid_reset();
    int n = 0;
    mode = 0;
    pulse2();
    while (vec2 != 2'd2 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (vec2 !== 2'd2) begin
      $display("FAIL midrst_reach: vec=%0d need 2", vec2);
      errors++;
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({vec2, ec2, fev2, busy2, done2, pass2, ev2} !== '0) begin
      $display("FAIL midrst_clear: got %b need 0", {vec2, ec2, fev2, busy2, done2, pass2, ev2});
      errors++;
    end
    tick();
    tick();
    tick();
    checks++;
    if (busy2 !== 1'b0 || vec2 !== 2'd0 || done2 !== 1'b0) begin
      $display("FAIL midrst_idle: busy=%b vec=%0d done=%b need 0 0 0", busy2, vec2, done2);
      errors++;
    end
    pulse2();
    checks++;
    if (busy2 !== 1'b1 || vec2 !== 2'd0) begin
      $display("FAIL midrst_restart: busy=%b vec=%0d need 1 0", busy2, vec2);
      errors++;
    end
    wait_done2("midrst_wait");
    check_result2("midrst", 3'd0, 2'b00, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    mode = 1;
    start2 = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    start2 = 1'b0;
    checks++;
    if (vec2 !== 2'd2 || busy2 !== 1'b1) begin
      $display("FAIL held_start: vec=%0d busy=%b need 2 1", vec2, busy2);
      errors++;
    end
    wait_done2("held_wait");
    check_result2("held", 3'd1, 2'b01, 1'b1, 1'b0);
    pulse2();
    checks++;
    if (ec2 !== 3'd0 || ev2 !== 1'b0 || done2 !== 1'b0) begin
      $display("FAIL b2b_clear: ec=%0d ev=%b done=%b need 0 0 0", ec2, ev2, done2);
      errors++;
    end
    wait_done2("b2b_wait");
    check_result2("b2b", 3'd1, 2'b01, 1'b1, 1'b0);
  endtask

  task automatic test_settle3();
    int edge_done = -1;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 3) begin
        checks++;
        if (vec3 !== 3'd0) begin
          $display("FAIL s3_hold: vec=%0d need 0", vec3);
          errors++;
        end
      end
      if (k == 4) begin
        checks++;
        if (vec3 !== 3'd1) begin
          $display("FAIL s3_step: vec=%0d need 1", vec3);
          errors++;
        end
      end
      if (done3 && edge_done < 0) edge_done = k;
    end
    checks++;
    if (edge_done !== 32) begin
      $display("FAIL s3_done_edge: edge=%0d need 32", edge_done);
      errors++;
    end
    checks++;
    if (pass3 !== 1'b1 || ec3 !== 4'd0 || ev3 !== 1'b0) begin
      $display("FAIL s3_result: pass=%b ec=%0d ev=%b need 1 0 0", pass3, ec3, ev3);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_equal();
    test_single_err();
    test_all_wrong();
    test_mid_reset();
    test_back_to_back();
    test_settle3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
